// File: rtl/hs_frame_decoder.sv
// hs_frame_decoder: 4-phase one-hot symbol receiver that assembles address/direction frames and drives per-channel up/down levels.
module hs_frame_decoder #(
  parameter int N_CH        = 4,
  parameter int ADDR_W      = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sym_fs,
  input  logic            sym_x0,
  input  logic            sym_one,
  input  logic            sym_zero,
  input  logic            sym_fd,
  input  logic            sym_fe,
  output logic            ack_fs,
  output logic            ack_x0,
  output logic            ack_one,
  output logic            ack_zero,
  output logic            ack_fd,
  output logic            ack_fe,
  output logic [N_CH-1:0] ch_up,
  output logic [N_CH-1:0] ch_down,
  output logic            frame_done,
  output logic            frame_err,
  output logic            busy
);
  localparam int CW = $clog2(ADDR_W + 2);
  localparam int FS = 0, X0 = 1, ONE = 2, ZERO = 3, FD = 4, FE = 5;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_END, S_ERR} state_t;
  state_t state, nxt;
  logic [5:0] raw, s, ack;
  logic [ADDR_W-1:0] addr;
  logic [CW-1:0] cnt;
  logic [N_CH-1:0] m;
  logic dir, done_p, err_p;
  logic any_ack, multi, acc, bit_sym, full, ok;
  logic clr, shift, ld_dir, commit, reject;
  assign raw = {sym_fe, sym_fd, sym_zero, sym_one, sym_x0, sym_fs};
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = raw;
    end else begin : g_sync
      logic [5:0] sr [SYNC_STAGES];
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
          for (int i = 0; i < SYNC_STAGES; i++) sr[i] <= '0;
        else begin
          sr[0] <= raw;
          for (int i = 1; i < SYNC_STAGES; i++) sr[i] <= sr[i-1];
        end
      assign s = sr[SYNC_STAGES-1];
    end
  endgenerate
  assign any_ack = |ack;
  assign multi   = |(s & (s - 6'd1));
  assign acc     = !any_ack && (s != 6'd0) && !multi;
  assign bit_sym = s[ONE] | s[ZERO];
  assign full    = cnt == CW'(ADDR_W);
  assign ok      = int'(addr) < N_CH;
  assign m       = N_CH'(1) << addr;
  assign {ack_fe, ack_fd, ack_zero, ack_one, ack_x0, ack_fs} = ack;
  always_comb begin
    nxt = state;
    clr = 1'b0;
    shift = 1'b0;
    ld_dir = 1'b0;
    commit = 1'b0;
    reject = 1'b0;
    if (multi && !any_ack) nxt = S_ERR;
    else if (acc)
      unique case (state)
        S_IDLE: begin
          clr = s[FS];
          nxt = s[FS] ? S_ADDR : S_IDLE;
        end
        S_ADDR: begin
          clr    = s[FS];
          shift  = bit_sym && !full;
          reject = s[FE];
          nxt    = s[FE] ? S_IDLE : bit_sym ? (full ? S_ERR : S_ADDR) :
                   s[X0] ? (full ? S_DATA : S_ERR) : S_ADDR;
        end
        S_DATA: begin
          ld_dir = bit_sym;
          reject = s[FE];
          nxt    = bit_sym ? S_END : s[FD] ? S_DATA : s[FE] ? S_IDLE : S_ERR;
        end
        S_END: begin
          commit = s[FE] && ok;
          reject = s[FE] && !ok;
          nxt    = s[FE] ? S_IDLE : s[FD] ? S_END : S_ERR;
        end
        default: begin
          reject = s[FE];
          nxt    = s[FE] ? S_IDLE : S_ERR;
        end
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= S_IDLE;
      ack        <= '0;
      addr       <= '0;
      cnt        <= '0;
      dir        <= 1'b0;
      busy       <= 1'b0;
      ch_up      <= '0;
      ch_down    <= '0;
      done_p     <= 1'b0;
      err_p      <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= nxt;
      ack        <= any_ack ? (ack & s) : acc ? s : 6'd0;
      addr       <= clr ? '0 : shift ? ((addr << 1) | ADDR_W'(s[ONE])) : addr;
      cnt        <= clr ? '0 : shift ? cnt + 1'b1 : cnt;
      dir        <= ld_dir ? s[ONE] : dir;
      busy       <= (acc && s[FE]) ? 1'b0 : (acc && s[FS]) ? 1'b1 : busy;
      ch_up      <= commit ? ((ch_up & ~m) | (dir ? m : '0)) : ch_up;
      ch_down    <= commit ? ((ch_down & ~m) | (dir ? '0 : m)) : ch_down;
      done_p     <= commit;
      err_p      <= reject;
      frame_done <= done_p;
      frame_err  <= err_p;
    end
endmodule
